// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and memory_interface.
// Issues one guarded access at a time, with overflow rejection and a WAIT timeout.
module mem_access_ctrl #(
    parameter int WIDE    = 16,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            req_we,
    input  logic [WIDE-1:0] req_addr,
    input  logic [WIDE-1:0] req_wdata,
    output logic            req_ready,
    output logic            done,
    output logic [WIDE-1:0] rdata,
    output logic            err,
    output logic [1:0]      err_code,
    output logic            mem_req,
    output logic [WIDE-1:0] mem_address,
    output logic [WIDE-1:0] mem_input_bus,
    output logic            mem_rw,
    input  logic [WIDE-1:0] mem_output_bus,
    input  logic            mem_valid,
    input  logic            mem_addr_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [WIDE-1:0] addr_q, addr_d;
    logic [WIDE-1:0] wdata_q, wdata_d;
    logic            rw_q, rw_d;
    logic [WIDE-1:0] rdata_q, rdata_d;
    logic [1:0]      err_code_q, err_code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            rdata_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rw_d    = req_we;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The overflow flag is combinational on the registered address,
                // so this is the first cycle it can be trusted.
                mem_req = 1'b1;
                if (mem_addr_overflow) begin
                    err_code_d = ERR_OVERFLOW;
                    state_d    = S_ERR;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    if (!rw_q) begin
                        rdata_d = mem_output_bus;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdata         = rdata_q;
    assign err_code      = err_code_q;
    assign mem_address   = addr_q;
    assign mem_input_bus = wdata_q;
    assign mem_rw        = rw_q;

endmodule
